// File: rtl/clb_multi.sv
// clb_multi: NUM_BLE LUT+FF logic elements with shadow-chain configuration and atomic commit.
// Define CLB_READBACK_EN to stream the previous shadow contents out on cfg_dout during a load.
module clb_multi #(
    parameter int LUT_K   = 4,
    parameter int NUM_BLE = 2
) (
    input  logic                       clb_clk,
    input  logic                       clb_rst,
    input  logic                       cfg_start,
    input  logic                       cfg_valid,
    input  logic                       cfg_data,
    output logic                       cfg_done,
    output logic                       cfg_dout,
    input  logic                       clb_ce,
    input  logic [NUM_BLE*LUT_K-1:0]   clb_input,
    output logic [NUM_BLE-1:0]         clb_output
);
    localparam int W        = 2**LUT_K + 2;
    localparam int CFG_BITS = NUM_BLE * W;
    localparam int CW       = $clog2(CFG_BITS + 1);

    typedef enum logic [1:0] {UNCONFIG, LOADING, ACTIVE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [CFG_BITS-1:0]   shadow, shadow_nxt, active;
    logic                  committed, accept, commit;
    logic [NUM_BLE-1:0]    ff, lut;

    always_comb begin
        accept     = state == LOADING && cfg_valid && !cfg_start;
        commit     = accept && cnt == CW'(CFG_BITS - 1);
        shadow_nxt = accept ? {cfg_data, shadow[CFG_BITS-1:1]} : shadow;
        state_nxt  = cfg_start ? LOADING : commit ? ACTIVE : state;
    end

    always_ff @(posedge clb_clk or posedge clb_rst) begin
        if (clb_rst) begin
            state     <= UNCONFIG;
            cnt       <= '0;
            shadow    <= '0;
            active    <= '0;
            committed <= 1'b0;
            ff        <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cfg_start ? '0 : accept ? cnt + 1'b1 : cnt;
            shadow <= shadow_nxt;
            if (commit) begin
                active    <= shadow_nxt;
                committed <= 1'b1;
            end
            // The commit edge seeds each FF from the incoming word, ignoring clb_ce
            for (int b = 0; b < NUM_BLE; b++)
                ff[b] <= commit ? shadow_nxt[b*W+1] : (clb_ce && committed) ? lut[b] : ff[b];
        end
    end

    for (genvar g = 0; g < NUM_BLE; g++) begin : g_ble
        logic [2**LUT_K-1:0] tbl;
        assign tbl           = active[g*W+2 +: 2**LUT_K];
        assign lut[g]        = tbl[clb_input[g*LUT_K +: LUT_K]];
        assign clb_output[g] = committed & (active[g*W] ? ff[g] : lut[g]);
    end

    assign cfg_done = state == ACTIVE;

`ifdef CLB_READBACK_EN
    always_ff @(posedge clb_clk or posedge clb_rst) begin
        if (clb_rst)
            cfg_dout <= 1'b0;
        else if (accept)
            cfg_dout <= shadow[0];
    end
`else
    assign cfg_dout = 1'b0;
`endif
endmodule
